// File: rtl/sc_spi_tgt.sv
// sc_spi_tgt: SPI target protocol engine. CSB/SCLK/MOSI are oversampled in the
// SPICLK domain; edges are detected after synchronization, so no SCLK-clocked
// logic exists. TX words arrive through a one-entry buffer, RX words leave as
// one-cycle RXVALID pulses.
// Build option: define SC_SPI_TGT_SYNC2_EN for two-flop pin synchronizers
// (pin-to-action latency 3 SPICLK); otherwise a single capture flop is used
// (latency 2), suitable only for pins already synchronous to SPICLK.
module sc_spi_tgt (
   input  logic        SPICLK,
   input  logic        SYSRSTB,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic [4:0]  DWIDTH,
   input  logic [31:0] TXDATA,
   input  logic        TXVALID,
   output logic        TXREADY,
   output logic        TXUNDER,
   output logic [31:0] RXDATA,
   output logic        RXVALID,
   output logic        FRMERR,
   output logic        BUSY,
   input  logic        CSB,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISOOE
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   // Pins are carried as {csb, sclk, mosi}; CSB resets high so a CSB held low
   // across reset release shows up as a fresh falling edge.
   localparam logic [2:0] PIN_RST = 3'b100;

   logic [2:0]  pin_s;
   logic [2:0]  pin_p_q;

`ifdef SC_SPI_TGT_SYNC2_EN
   logic [2:0]  meta_q;
   logic [2:0]  sync_q;

   // Two-flop synchronizer on the asynchronous SPI pins.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      if (!SYSRSTB) begin
         meta_q <= PIN_RST;
         sync_q <= PIN_RST;
      end else begin
         meta_q <= {CSB, SCLK, MOSI};
         sync_q <= meta_q;
      end
   end
`else
   logic [2:0]  sync_q;

   // Single capture flop for pins that are already SPICLK-synchronous.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      if (!SYSRSTB) sync_q <= PIN_RST;
      else          sync_q <= {CSB, SCLK, MOSI};
   end
`endif

   assign pin_s = sync_q;

   // Edge-detect register: previous synchronized pin values.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) pin_p_q <= PIN_RST;
      else          pin_p_q <= pin_s;
   end

   state_t      state_q, state_d;
   logic        cpol_q, cpol_d, cpha_q, cpha_d;
   logic [4:0]  dwidth_q, dwidth_d, bc_q, bc_d;
   logic [31:0] txsr_q, txsr_d, rxsr_q, rxsr_d;
   logic [31:0] txbuf_q, txbuf_d, rxdata_q, rxdata_d;
   logic        txbuf_vld_q, txbuf_vld_d, txready_q, txready_d;
   logic        rxvalid_q, rxvalid_d, txunder_q, txunder_d, frmerr_q, frmerr_d;

   logic        csb_fall, csb_rise, sclk_rise, sclk_fall;
   logic        sample_edge, shift_edge, fetch, wr_acc;
   logic [31:0] rx_next, rx_mask;

   assign csb_fall    = pin_p_q[2] & ~pin_s[2];
   assign csb_rise    = ~pin_p_q[2] & pin_s[2];
   assign sclk_rise   = ~pin_p_q[1] & pin_s[1];
   assign sclk_fall   = pin_p_q[1] & ~pin_s[1];
   // Modes 0/3 sample on SCLK rising, modes 1/2 on SCLK falling.
   assign sample_edge = (cpol_q ^ cpha_q) ? sclk_fall : sclk_rise;
   assign shift_edge  = (cpol_q ^ cpha_q) ? sclk_rise : sclk_fall;
   assign rx_next     = {rxsr_q[30:0], pin_s[0]};
   assign rx_mask     = 32'hFFFF_FFFF >> (5'd31 - dwidth_q);
   assign wr_acc      = TXVALID & txready_q;

   // Next-state logic: frame FSM, bit counter, shift registers and TX buffer.
   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can infer a latch.
      state_d     = state_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      dwidth_d    = dwidth_q;
      bc_d        = bc_q;
      txsr_d      = txsr_q;
      rxsr_d      = rxsr_q;
      rxdata_d    = rxdata_q;
      txbuf_d     = txbuf_q;
      txbuf_vld_d = txbuf_vld_q;
      rxvalid_d   = 1'b0;
      txunder_d   = 1'b0;
      frmerr_d    = 1'b0;
      fetch       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (csb_fall) begin
               state_d  = ACTIVE;
               cpol_d   = CPOL;
               cpha_d   = CPHA;
               dwidth_d = DWIDTH;
               bc_d     = 5'd0;
               fetch    = ~CPHA;
            end
         end
         ACTIVE: begin
            if (sample_edge) begin
               rxsr_d = rx_next;
               if (bc_q == dwidth_q) begin
                  rxdata_d  = rx_next & rx_mask;
                  rxvalid_d = 1'b1;
                  bc_d      = 5'd0;
               end else begin
                  bc_d = bc_q + 5'd1;
               end
            end else if (shift_edge) begin
               if (bc_q == 5'd0) fetch = 1'b1;
               else              txsr_d = txsr_q << 1;
            end
            // The abort check sees the count after any same-cycle sample.
            if (csb_rise) begin
               state_d  = IDLE;
               frmerr_d = (bc_d != 5'd0);
            end
         end
         default: state_d = IDLE;
      endcase

      // Fetch uses the pre-edge buffer state, so a coincident write into an
      // empty buffer still underruns and waits for the next fetch.
      if (fetch) begin
         if (txbuf_vld_q) begin
            txsr_d      = txbuf_q;
            txbuf_vld_d = 1'b0;
         end else begin
            txsr_d    = 32'd0;
            txunder_d = 1'b1;
         end
      end
      if (wr_acc) begin
         txbuf_d     = TXDATA;
         txbuf_vld_d = 1'b1;
      end
      // TXREADY drops with the accepting edge and rises one cycle after the
      // fetch that empties the buffer.
      txready_d = ~txbuf_vld_q & ~wr_acc;
   end

   // State and datapath registers.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         state_q     <= IDLE;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         dwidth_q    <= 5'd0;
         bc_q        <= 5'd0;
         txsr_q      <= 32'd0;
         rxsr_q      <= 32'd0;
         rxdata_q    <= 32'd0;
         txbuf_q     <= 32'd0;
         txbuf_vld_q <= 1'b0;
         txready_q   <= 1'b1;
         rxvalid_q   <= 1'b0;
         txunder_q   <= 1'b0;
         frmerr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         dwidth_q    <= dwidth_d;
         bc_q        <= bc_d;
         txsr_q      <= txsr_d;
         rxsr_q      <= rxsr_d;
         rxdata_q    <= rxdata_d;
         txbuf_q     <= txbuf_d;
         txbuf_vld_q <= txbuf_vld_d;
         txready_q   <= txready_d;
         rxvalid_q   <= rxvalid_d;
         txunder_q   <= txunder_d;
         frmerr_q    <= frmerr_d;
      end
   end

   assign TXREADY = txready_q;
   assign TXUNDER = txunder_q;
   assign RXDATA  = rxdata_q;
   assign RXVALID = rxvalid_q;
   assign FRMERR  = frmerr_q;
   assign BUSY    = (state_q == ACTIVE);
   assign MISOOE  = (state_q == ACTIVE);
   assign MISO    = (state_q == ACTIVE) ? txsr_q[dwidth_q] : 1'b0;

endmodule

// File: doc/sc_spi_tgt.md
# sc_spi_tgt

SPI target (slave) protocol engine: the far end of the SPI protocol engine's link. It receives frames driven by an external SPI master on CSB/SCLK/MOSI and returns data on MISO. The block oversamples all SPI pins in the SPICLK domain, so no SCLK-clocked logic exists. It sits between the SPI pads and a register/FIFO front end, which supplies TX words through a one-entry buffer and takes RX words as one-cycle pulses.

## Interface
Parameters: none.

Ports:
- SPICLK  in  1  system clock. One clock; all logic is on the rising edge.
- SYSRSTB  in  1  reset, asynchronous, active-low.
- CPOL  in  1  clock polarity. Latched at frame start.
- CPHA  in  1  clock phase. Latched at frame start.
- DWIDTH  in  5  word length minus 1 (1..32 bits). Latched at frame start.
- TXDATA  in  32  next TX word, right-aligned, MSB = bit DWIDTH.
- TXVALID  in  1  TXDATA valid.
- TXREADY  out  1  TX buffer empty. A write is accepted when TXVALID & TXREADY.
- TXUNDER  out  1  1-cycle pulse: a fetch found the buffer empty, so zeros are sent.
- RXDATA  out  32  last received word, zero-extended above bit DWIDTH.
- RXVALID  out  1  1-cycle pulse: RXDATA updated.
- FRMERR  out  1  1-cycle pulse: CSB rose mid-word.
- BUSY  out  1  frame active.
- CSB, SCLK, MOSI  in  1 each  SPI pins, asynchronous.
- MISO  out  1  target data out.
- MISOOE  out  1  MISO output enable.

## Operation
- Pin capture:
  - CSB, SCLK and MOSI pass through synchronizers, then one edge-detect register.
  - Sample edge = SCLK rising when CPOL^CPHA = 0, else SCLK falling. Shift edge = the opposite SCLK edge.
- State machine, two states:
  - IDLE → ACTIVE on synced CSB falling. On entry:
    - latch CPOL, CPHA and DWIDTH;
    - set bc = 0;
    - if CPHA = 0, fetch.
  - ACTIVE → IDLE on synced CSB rising.
    - If bc ≠ 0, pulse FRMERR and discard the partial word.
- Fetch:
  - If the buffer is valid: txsr <= buffer, buffer becomes empty.
  - If the buffer is empty: txsr <= 0, pulse TXUNDER.
- Sample edge while ACTIVE:
  - rxsr <= {rxsr[30:0], MOSI}.
  - If bc == DWIDTH: RXDATA <= new rxsr masked to DWIDTH+1 bits, pulse RXVALID, bc <= 0.
  - Otherwise: bc <= bc + 1.
- Shift edge while ACTIVE:
  - If bc == 0, fetch.
  - Otherwise, txsr <= txsr << 1.
  - Result: CPHA = 1 fetches on the first edge of every word; CPHA = 0 fetches at the trailing edge of each word, for the next word.
- Data outputs:
  - MISO = txsr[DWIDTH] while ACTIVE, else 0.
  - MISOOE = BUSY = (state == ACTIVE).
- Data order is MSB first. Words stream back-to-back with no CSB gap.
- In CPHA = 0, the fetch at the trailing shift edge of the last word consumes the buffer. That word is discarded if CSB then rises.

## Timing
- Reset values:
  - state IDLE, bc = 0, txsr = 0, rxsr = 0, buffer empty;
  - TXREADY = 1; RXDATA = 0;
  - RXVALID, TXUNDER, FRMERR, BUSY, MISO, MISOOE = 0.
- Reset mid-frame aborts immediately, with no FRMERR. Because of the synchronizers, a CSB still low after reset release is seen as a new falling edge.
- Pin-to-action latency L = sync stages + 1 SPICLK. L = 3 with SC_SPI_TGT_SYNC2_EN, L = 2 without.
- Output timing:
  - MISO changes L cycles after the pin shift edge.
  - RXVALID asserts L cycles after the last sample edge of a word.
  - TXREADY rises the cycle after a fetch from a full buffer.
- SPICLK must be ≥ 2·(L+1)× the SCLK frequency. SCLK high and low phases must each be ≥ L+1 SPICLK.
- Write coincident with a fetch while the buffer is empty:
  - the fetch underruns and sends 0;
  - the write is still accepted and serves the next fetch.
- CSB rising and a sample edge in the same cycle: the sample is taken first, then the abort check uses the updated bc.

## Configuration
- SC_SPI_TGT_SYNC2_EN defined: two-flop synchronizers on CSB, SCLK and MOSI, giving L = 3.
- Not defined: single capture flop, giving L = 2. Use only when the pins are already synchronous to SPICLK.
- Functional behaviour is otherwise identical.

## Test plan
- Mode 0, DWIDTH = 7, TXDATA = 0xA5 written before CSB falls; master sends 0x3C.
  - MISO bits 1,0,1,0,0,1,0,1.
  - RXDATA = 0x0000003C with a single RXVALID pulse.
  - TXREADY goes high L+1 cycles after CSB falls.
- Mode 3, DWIDTH = 31, TXDATA 0xDEADBEEF then 0x12345678 (refilled when TXREADY rises); master sends two words 0xCAFEF00D, 0x0BADC0DE in one frame.
  - Both words appear on MISO.
  - Two RXVALID pulses with the matching RXDATA.
  - No TXUNDER.
- Mode 1, DWIDTH = 15, buffer never written.
  - TXUNDER pulses at the first shift edge.
  - MISO stays 0 for 16 bits.
  - RXVALID still pulses.
- Mode 2, DWIDTH = 7; CSB rises after 5 clocks.
  - FRMERR pulses once, no RXVALID.
  - BUSY and MISOOE go to 0 L cycles after CSB rises.
  - The next frame receives correctly.
- SYSRSTB pulsed low mid-word in mode 0.
  - All outputs return to their reset values.
  - TXREADY = 1, and a following full frame works.
- Build without SC_SPI_TGT_SYNC2_EN.
  - Repeat the first scenario.
  - RXVALID and MISO transitions occur exactly one SPICLK earlier than in the default build.
